// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings and counter sizing for the universal shift register.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// Saturating up-counter: synchronous zero takes priority over increment.
module sat_counter #(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         zero,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (zero) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register/serialiser: hold, shift left/right, parallel load, sync clear,
// with a saturating shift counter flagging a fully serialised word.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RST_VAL     = '0,
    parameter bit               SYNC_CLR_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic [1:0]                mode,
    input  logic [WIDTH-1:0]          d,
    input  logic                      ser_lsb,
    input  logic                      ser_msb,
    output logic [WIDTH-1:0]          q,
    output logic                      sout_l,
    output logic                      sout_r,
    output logic [cnt_w(WIDTH)-1:0]   cnt,
    output logic                      done
);

    localparam int CW = cnt_w(WIDTH);

    mode_e            op;
    logic             clr_act;
    logic             shifting;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] next_q;

    assign op       = mode_e'(mode);
    assign clr_act  = SYNC_CLR_EN && clr;
    assign shifting = en && ((op == MODE_SHL) || (op == MODE_SHR));

    // A single-bit register has no retained bits, so a shift just takes the serial input.
    if (WIDTH == 1) begin : g_w1
        assign shl_val = ser_lsb;
        assign shr_val = ser_msb;
    end else begin : g_wn
        assign shl_val = {q[WIDTH-2:0], ser_lsb};
        assign shr_val = {ser_msb, q[WIDTH-1:1]};
    end

    always_comb begin
        next_q = q;
        case (op)
            MODE_SHL:  next_q = shl_val;
            MODE_SHR:  next_q = shr_val;
            MODE_LOAD: next_q = d;
            default:   next_q = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr_act) begin
            q <= '0;
        end else if (en) begin
            q <= next_q;
        end
    end

    sat_counter #(
        .MAX (WIDTH),
        .W   (CW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (shifting && !clr_act),
        .zero (clr_act || (en && (op == MODE_LOAD))),
        .cnt  (cnt)
    );

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign done   = (cnt == CW'(WIDTH));

endmodule
